wb_cmd_master: RTL

//  Wishbone classic single-transfer initiator. It is the bus-master end for the tjrpu-style

---
 rtl/tilerisc_wb_defs.sv | 19 +
 rtl/wb_cmd_master_timeout.sv | 40 ++++
 rtl/wb_cmd_master.sv | 110 +++++++++++
 3 files changed

// File: rtl/tilerisc_wb_defs.sv
// Shared Wishbone definitions for the tilerisc bus blocks: default widths,
// the master FSM encoding and a timer-width helper.
package tilerisc_wb_defs;

  localparam int WB_DATA_W = 32;
  localparam int WB_ADDR_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } wb_state_t;

  // A disabled timeout (0) still needs a legal 1-bit vector.
  function automatic int wb_timer_width(input int timeout);
    return (timeout > 0) ? $clog2(timeout + 1) : 1;
  endfunction

endpackage

// File: rtl/wb_cmd_master_timeout.sv
// Cycle counter for the BUS phase; expired is high in the cycle whose edge
// completes TIMEOUT strobe cycles without an acknowledge.
module wb_timeout_counter
  import tilerisc_wb_defs::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = wb_timer_width(TIMEOUT);

  generate
    if (TIMEOUT == 0) begin : g_disabled
      logic unused_inputs;
      assign unused_inputs = &{1'b0, clk, reset, clear, enable};
      assign expired       = 1'b0;
    end else begin : g_enabled
      logic [CNT_W-1:0] count_reg;

      // Cleared on every accept, so the count never exceeds TIMEOUT.
      always_ff @(posedge clk) begin
        if (reset) begin
          count_reg <= '0;
        end else if (clear) begin
          count_reg <= '0;
        end else if (enable) begin
          count_reg <= count_reg + CNT_W'(1);
        end
      end

      assign expired = enable && (count_reg == CNT_W'(TIMEOUT - 1));
    end
  endgenerate

endmodule

// File: rtl/wb_cmd_master.sv
// Wishbone classic single-transfer initiator: one command in over valid/ready,
// one bus cycle, one response (read data or timeout error) out over valid/ready.
module wb_cmd_master
  import tilerisc_wb_defs::*;
#(
  parameter  int ADDR_W  = WB_ADDR_W,
  parameter  int DATA_W  = WB_DATA_W,
  parameter  int TIMEOUT = 255,
  localparam int SEL_W   = DATA_W / 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_we,
  input  logic [ADDR_W-1:0] cmd_adr,
  input  logic [DATA_W-1:0] cmd_dat,
  input  logic [SEL_W-1:0]  cmd_sel,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_dat,
  output logic              rsp_err,
  output logic              busy,
  output logic              wbm_cyc_o,
  output logic              wbm_stb_o,
  output logic              wbm_we_o,
  output logic [SEL_W-1:0]  wbm_sel_o,
  output logic [ADDR_W-1:0] wbm_adr_o,
  output logic [DATA_W-1:0] wbm_dat_o,
  input  logic [DATA_W-1:0] wbm_dat_i,
  input  logic              wbm_ack_i
);

  wb_state_t state_reg;
  logic      timer_expired;
  logic      cmd_accept;

  assign cmd_ready  = (state_reg == IDLE);
  assign busy       = (state_reg != IDLE);
  assign cmd_accept = cmd_valid && (state_reg == IDLE);
  assign wbm_stb_o  = wbm_cyc_o;

  wb_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clear   (cmd_accept),
    .enable  (state_reg == BUS),
    .expired (timer_expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      wbm_cyc_o <= 1'b0;
      wbm_we_o  <= 1'b0;
      wbm_sel_o <= '0;
      wbm_adr_o <= '0;
      wbm_dat_o <= '0;
      rsp_valid <= 1'b0;
      rsp_dat   <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (cmd_valid) begin
            wbm_we_o  <= cmd_we;
            wbm_adr_o <= cmd_adr;
            wbm_dat_o <= cmd_dat;
            wbm_sel_o <= cmd_sel;
            wbm_cyc_o <= 1'b1;
            state_reg <= BUS;
          end
        end
        BUS: begin
          // An ack arriving on the timeout edge still completes the transfer.
          if (wbm_ack_i) begin
            rsp_dat   <= wbm_we_o ? '0 : wbm_dat_i;
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
            wbm_cyc_o <= 1'b0;
            wbm_we_o  <= 1'b0;
            state_reg <= RESP;
          end else if (timer_expired) begin
            rsp_dat   <= '0;
            rsp_err   <= 1'b1;
            rsp_valid <= 1'b1;
            wbm_cyc_o <= 1'b0;
            wbm_we_o  <= 1'b0;
            state_reg <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: begin
          wbm_cyc_o <= 1'b0;
          wbm_we_o  <= 1'b0;
          rsp_valid <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule
